systolic_skew_feeder: RTL and testbench
=======================================

# systolic_skew_feeder

West-edge (or north-edge) operand feeder for the FP16 systolic MAC array. Buffers one tile of operand vectors from an upstream valid/ready stream, then releases it as a contiguous, diagonally skewed stream: lane i is delayed i cycles. After the stream it issues the one-cycle done pulse that moves every processing element from accumulate to final-sum. Two instances, one for A rows and one for B columns, are started by the same `start` so their skews align.

## Interface
- `WIDTH`, 16, element width in bits.
- `EXP_BITS`, 5, FP exponent field width.
- `FRAC_BITS`, 10, FP fraction field width. `EXP_BITS + FRAC_BITS + 1 == WIDTH`.
- `LANES`, 4, number of array rows/columns fed.
- `DEPTH`, 8, maximum vectors per tile (FIFO depth), ≥ 2.
- `DONE_DELAY`, 4, extra cycles between the last element leaving lane `LANES-1` and the `done` pulse. Covers array traversal plus PE pipeline.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  upstream vector valid.
- `in_ready`  out  1  feeder accepts a vector this cycle.
- `in_data`  in  `LANES*WIDTH`  vector; element i in bits `[i*WIDTH +: WIDTH]`.
- `in_last`  in  1  marks the final vector of the tile.
- `primed`  out  1  tile fully buffered, waiting for `start`.
- `start`  in  1  begin streaming; honoured only while `primed`.
- `busy`  out  1  high in STREAM and FLUSH.
- `truncated`  out  1  sticky: the tile was auto-closed at `DEPTH` without `in_last`. Cleared on the next accepted vector in IDLE.
- `lane_out`  out  `LANES*WIDTH`  skewed operands to the array edge.
- `done`  out  1  one-cycle pulse to the array's `in_done_flag`.

## Operation
- States:
  - **IDLE**: `in_ready=1`. The first accepted vector moves the block to FILL.
  - **FILL**: `in_ready = (count<DEPTH)`.
    - An accepted vector with `in_last`, or `count` reaching `DEPTH`, moves the block to PRIMED.
    - In the `DEPTH` case, `truncated` is set.
  - **PRIMED**: `primed=1`, `in_ready=0`. `start` moves the block to STREAM.
  - **STREAM**: pops one vector per cycle into the skew stage, `L` cycles for `L` buffered vectors, then moves to FLUSH.
  - **FLUSH**: counts `LANES-1+DONE_DELAY` cycles, pulses `done` on the last, then returns to IDLE.
- An accept in IDLE that carries `in_last` goes directly to PRIMED with `L=1`.
- Skew stage:
  - Lane i is a shift chain of i registers after a common output register, giving `LANES*(LANES-1)/2 + LANES` element registers.
  - Every chain shifts every cycle.
  - Outside STREAM, zero is injected at the chain head.
- `lane_out` lanes not carrying tile data are `16'h0000`. +0 accumulates harmlessly.
- Counters:
  - FIFO count is `$clog2(DEPTH+1)` bits.
  - Read and write pointers wrap modulo `DEPTH`.
  - The FIFO is fully drained every tile, and pointers reset to 0 on IDLE entry.
- `in_valid` outside IDLE/FILL is ignored; `in_ready` is 0 there.
- `start` outside PRIMED is ignored.
- `start` and `in_valid` in the same cycle in PRIMED: `start` wins and `in_valid` is not accepted.
- Reset at any point, mid-stream included:
  - State goes to IDLE, FIFO is emptied, all skew registers are cleared.
  - All outputs return to 0 (`in_ready`, `primed`, `busy`, `truncated`, `lane_out`, `done`), except `in_ready`, which is 1 from the first cycle after reset deasserts.
  - No `done` pulse is emitted for an aborted tile.

## Timing
- All outputs are registered, except `in_ready`, `primed` and `busy`, which decode the state register.
- Accept: a handshake occurs on an edge with `in_valid & in_ready`.
- With `start` sampled at edge T:
  - Element i of vector j appears on lane i from edge `T+1+j+i` for one cycle.
  - `busy` is high from T+1.
  - The last element is on lane `LANES-1` at `T+L+LANES-1`.
- `done` is high for exactly the cycle after edge `T+L+LANES-1+DONE_DELAY`. IDLE is re-entered on the same edge that drops `done`.
- Back-to-back tiles: the next tile's FILL may begin the cycle after `done`.

## Configuration
- `SKEW_FEEDER_FTZ_EN` defined: every element is flushed to signed zero at FIFO write if it is subnormal (exponent field 0, fraction ≠ 0). For FP16, `16'h8001` is stored as `16'h8000` and `16'h0200` as `16'h0000`.
- Undefined: elements are stored and emitted bit-exact.
- No other behaviour differs.

## Test plan
- **Basic skew**: `LANES=4`, tile of 3 vectors with lane values `{0x3C00+ j*4+i}`, last on j=2, `start` at edge T.
  - Lane 2 carries `0x3C02,0x3C06,0x3C0A` at T+3..T+5.
  - Zeros elsewhere.
  - `done` is high in the cycle after edge T+3+3+4=T+10.
- **Truncation**: 8 vectors without `in_last`.
  - `in_ready` drops after the 8th accept.
  - `primed=1`, `truncated=1`.
  - The 9th `in_valid` is held off.
- **Start gating**: `start` pulsed in FILL produces no output. `start` in PRIMED concurrent with `in_valid` starts streaming and accepts nothing.
- **Reset mid-STREAM** at T+2:
  - `lane_out` is all zero next cycle, with no `done`.
  - `in_ready=1` after reset release.
  - A new 1-vector tile then streams correctly.
- **FTZ**: element `16'h8001`.
  - Lane output is `16'h8000` with `SKEW_FEEDER_FTZ_EN`, and `16'h8001` without it.
- **Back-to-back**: two 2-vector tiles, second `start` immediately after priming. Two `done` pulses, with no overlap of tile data on any lane.

Source files
------------

// File: rtl/systolic_skew_feeder_if.sv
// Upstream valid/ready operand-vector stream
// feeding systolic_skew_feeder.
interface systolic_skew_feeder_if #(
  parameter int WIDTH = 16,
  parameter int LANES = 4
);
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*WIDTH-1:0] in_data;
  logic                   in_last;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    output in_ready
  );
endinterface

// File: rtl/systolic_skew_feeder.sv
// Tile buffer + diagonal skew feeder for the FP16 systolic MAC array.
// Define SKEW_FEEDER_FTZ_EN to flush subnormals to signed zero at write.
module systolic_skew_feeder #(
  parameter int WIDTH      = 16,
  parameter int EXP_BITS   = 5,
  parameter int FRAC_BITS  = 10,
  parameter int LANES      = 4,
  parameter int DEPTH      = 8,
  parameter int DONE_DELAY = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  systolic_skew_feeder_if.slave  up,
  output logic                   primed,
  input  logic                   start,
  output logic                   busy,
  output logic                   truncated,
  output logic [LANES*WIDTH-1:0] lane_out,
  output logic                   done
);

  localparam int CW      = $clog2(DEPTH + 1);
  localparam int PW      = $clog2(DEPTH);
  localparam int FLUSH_N = LANES - 1 + DONE_DELAY;
  localparam int FW      = $clog2(FLUSH_N + 1);

`ifdef SKEW_FEEDER_FTZ_EN
  localparam bit FTZ_EN = 1'b1;
`else
  localparam bit FTZ_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_PRIMED,
    S_STREAM,
    S_FLUSH
  } state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          count_q, count_d;
  logic [PW-1:0]          wr_q, wr_d;
  logic [PW-1:0]          rd_q, rd_d;
  logic [FW-1:0]          fc_q, fc_d;
  logic                   trunc_q, trunc_d;
  logic                   done_q, done_d;
  logic [LANES*WIDTH-1:0] head_q, head_d;
  logic [LANES*WIDTH-1:0] mem_q [DEPTH];
  logic [LANES*WIDTH-1:0] wdata;
  logic                   rdy, accept, push, pop;

  function automatic logic [WIDTH-1:0] ftz(
    input logic [WIDTH-1:0] e
  );
    logic [EXP_BITS-1:0]  ex;
    logic [FRAC_BITS-1:0] fr;
    ex = e[FRAC_BITS +: EXP_BITS];
    fr = e[FRAC_BITS-1:0];
    if (FTZ_EN && ex == '0 && fr != '0)
      return {e[WIDTH-1], {(WIDTH-1){1'b0}}};
    return e;
  endfunction

  always_comb begin
    wdata = '0;
    for (int i = 0; i < LANES; i++)
      wdata[i*WIDTH +: WIDTH] = ftz(up.in_data[i*WIDTH +: WIDTH]);
  end

  assign rdy = (state_q == S_IDLE) ||
               (state_q == S_FILL && count_q < CW'(DEPTH));
  assign accept = up.in_valid && rdy;

  // Held low during reset; IDLE is already decoded then.
  assign up.in_ready = rdy && !reset;
  assign primed      = (state_q == S_PRIMED);
  assign busy        = (state_q == S_STREAM) ||
                       (state_q == S_FLUSH);
  assign truncated   = trunc_q;
  assign done        = done_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    fc_d    = fc_q;
    trunc_d = trunc_q;
    done_d  = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          push    = 1'b1;
          trunc_d = 1'b0;
          state_d = up.in_last ? S_PRIMED : S_FILL;
        end
      end
      S_FILL: begin
        if (accept) begin
          push = 1'b1;
          if (up.in_last) begin
            state_d = S_PRIMED;
          end else if (count_q == CW'(DEPTH - 1)) begin
            state_d = S_PRIMED;
            trunc_d = 1'b1;
          end
        end
      end
      S_PRIMED: begin
        if (start) state_d = S_STREAM;
      end
      S_STREAM: begin
        pop = 1'b1;
        if (count_q == CW'(1)) begin
          state_d = S_FLUSH;
          fc_d    = '0;
        end
      end
      S_FLUSH: begin
        fc_d = fc_q + 1'b1;
        if (fc_q == FW'(FLUSH_N - 1)) done_d = 1'b1;
        if (fc_q == FW'(FLUSH_N)) begin
          state_d = S_IDLE;
          wr_d    = '0;
          rd_d    = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (push) begin
      count_d = count_q + 1'b1;
      wr_d    = (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
    end
    if (pop) begin
      count_d = count_q - 1'b1;
      rd_d    = (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
    end
  end

  // Zero enters the chain heads whenever no tile data is being popped.
  assign head_d = pop ? mem_q[rd_q] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      fc_q    <= '0;
      trunc_q <= 1'b0;
      done_q  <= 1'b0;
      head_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      fc_q    <= fc_d;
      trunc_q <= trunc_d;
      done_q  <= done_d;
      head_q  <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= wdata;
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    if (i == 0) begin : g_head
      assign lane_out[0 +: WIDTH] = head_q[0 +: WIDTH];
    end else begin : g_chain
      logic [WIDTH-1:0] chain_q [i];
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int k = 0; k < i; k++) chain_q[k] <= '0;
        end else begin
          chain_q[0] <= head_q[i*WIDTH +: WIDTH];
          for (int k = 1; k < i; k++) chain_q[k] <= chain_q[k-1];
        end
      end
      assign lane_out[i*WIDTH +: WIDTH] = chain_q[i-1];
    end
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder (LANES=4, DEPTH=8,
// DONE_DELAY=4); honours SKEW_FEEDER_FTZ_EN for the FTZ case.
module tb_systolic_skew_feeder;
  localparam int W  = 16;
  localparam int LN = 4;
  localparam int DP = 8;
  localparam int FN = LN - 1 + 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic            primed, busy, truncated, done;
  logic [LN*W-1:0] lane_out;
  logic [LN*W-1:0] tile [DP];
  int              total = 0;
  int              bad = 0;

  systolic_skew_feeder_if #(.WIDTH(W), .LANES(LN)) up();

  systolic_skew_feeder dut (
    .clk       (clk),
    .reset     (reset),
    .up        (up),
    .primed    (primed),
    .start     (start),
    .busy      (busy),
    .truncated (truncated),
    .lane_out  (lane_out),
    .done      (done)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] exp_lane(
    input int i, input int k, input int len
  );
    int j;
    j = k - 1 - i;
    if (j >= 0 && j < len) return tile[j][i*W +: W];
    return '0;
  endfunction

  task automatic push(input logic [LN*W-1:0] d, input logic last);
    int n;
    up.in_valid = 1'b1;
    up.in_data  = d;
    up.in_last  = last;
    n = 0;
    while (up.in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      total++; bad++;
      $display("FAIL push_timeout ready=%b want=1", up.in_ready);
    end
    @(negedge clk);
    up.in_valid = 1'b0;
    up.in_last  = 1'b0;
  endtask

  task automatic fire_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic set_tile(input int len, input logic [15:0] base);
    for (int j = 0; j < len; j++)
      for (int i = 0; i < LN; i++)
        tile[j][i*W +: W] = 16'(base + j*4 + i);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({up.in_ready, primed, busy, truncated, done} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b want=00000",
               {up.in_ready, primed, busy, truncated, done});
    end
    total++;
    if (lane_out !== '0) begin
      bad++; $display("FAIL reset_lanes got=%h want=0", lane_out);
    end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (up.in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ready got=%b want=1", up.in_ready);
    end
  endtask

  task automatic test_basic_skew();
    set_tile(3, 16'h3C00);
    for (int j = 0; j < 3; j++) push(tile[j], j == 2);
    total++;
    if (primed !== 1'b1 || truncated !== 1'b0) begin
      bad++;
      $display("FAIL basic_primed got=%b%b want=10", primed, truncated);
    end
    fire_start();
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      for (int i = 0; i < LN; i++) begin
        total++;
        if (lane_out[i*W +: W] !== exp_lane(i, k, 3)) begin
          bad++;
          $display("FAIL basic_lane%0d k=%0d got=%h want=%h",
                   i, k, lane_out[i*W +: W], exp_lane(i, k, 3));
        end
      end
      total++;
      if (done !== (k == 3 + FN)) begin
        bad++; $display("FAIL basic_done k=%0d got=%b", k, done);
      end
      total++;
      if (busy !== (k <= 3 + FN)) begin
        bad++; $display("FAIL basic_busy k=%0d got=%b", k, busy);
      end
    end
    total++;
    if (up.in_ready !== 1'b1) begin
      bad++; $display("FAIL basic_idle ready=%b want=1", up.in_ready);
    end
  endtask

  task automatic test_truncation();
    set_tile(8, 16'h1000);
    for (int j = 0; j < 8; j++) push(tile[j], 1'b0);
    total++;
    if ({up.in_ready, primed, truncated} !== 3'b011) begin
      bad++;
      $display("FAIL trunc_flags got=%b want=011",
               {up.in_ready, primed, truncated});
    end
    up.in_valid = 1'b1;
    up.in_data  = '1;
    repeat (3) begin
      @(negedge clk);
      total++;
      if (up.in_ready !== 1'b0 || primed !== 1'b1) begin
        bad++;
        $display("FAIL trunc_holdoff got=%b%b want=01",
                 up.in_ready, primed);
      end
    end
    up.in_valid = 1'b0;
    fire_start();
    for (int k = 1; k <= 8 + FN + 1; k++) begin
      @(negedge clk);
      for (int i = 0; i < LN; i++) begin
        total++;
        if (lane_out[i*W +: W] !== exp_lane(i, k, 8)) begin
          bad++;
          $display("FAIL trunc_lane%0d k=%0d got=%h want=%h",
                   i, k, lane_out[i*W +: W], exp_lane(i, k, 8));
        end
      end
      total++;
      if (done !== (k == 8 + FN)) begin
        bad++; $display("FAIL trunc_done k=%0d got=%b", k, done);
      end
    end
    total++;
    if (truncated !== 1'b1) begin
      bad++; $display("FAIL trunc_sticky got=%b want=1", truncated);
    end
  endtask

  task automatic test_start_gating();
    set_tile(2, 16'h4400);
    push(tile[0], 1'b0);
    total++;
    if (truncated !== 1'b0) begin
      bad++; $display("FAIL gate_trunc_clr got=%b want=0", truncated);
    end
    fire_start();
    repeat (3) begin
      @(negedge clk);
      total++;
      if ({busy, primed} !== 2'b00 || lane_out !== '0) begin
        bad++;
        $display("FAIL gate_fill_start busy=%b primed=%b lanes=%h",
                 busy, primed, lane_out);
      end
    end
    push(tile[1], 1'b1);
    start       = 1'b1;
    up.in_valid = 1'b1;
    up.in_data  = 64'hDEAD_BEEF_0BAD_F00D;
    up.in_last  = 1'b1;
    @(negedge clk);
    start       = 1'b0;
    up.in_valid = 1'b0;
    up.in_last  = 1'b0;
    total++;
    if ({busy, up.in_ready} !== 2'b10) begin
      bad++;
      $display("FAIL gate_race got=%b%b want=10", busy, up.in_ready);
    end
    for (int k = 1; k <= 2 + FN + 1; k++) begin
      @(negedge clk);
      for (int i = 0; i < LN; i++) begin
        total++;
        if (lane_out[i*W +: W] !== exp_lane(i, k, 2)) begin
          bad++;
          $display("FAIL gate_lane%0d k=%0d got=%h want=%h",
                   i, k, lane_out[i*W +: W], exp_lane(i, k, 2));
        end
      end
      total++;
      if (done !== (k == 2 + FN)) begin
        bad++; $display("FAIL gate_done k=%0d got=%b", k, done);
      end
    end
  endtask

  task automatic test_reset_mid();
    set_tile(2, 16'h5000);
    push(tile[0], 1'b0);
    push(tile[1], 1'b1);
    fire_start();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (lane_out !== '0 || {done, busy, up.in_ready} !== 3'b000) begin
      bad++;
      $display("FAIL rst_mid lanes=%h flags=%b want=0/000",
               lane_out, {done, busy, up.in_ready});
    end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (up.in_ready !== 1'b1) begin
      bad++; $display("FAIL rst_mid_ready got=%b want=1", up.in_ready);
    end
    repeat (10) begin
      @(negedge clk);
      total++;
      if (done !== 1'b0) begin
        bad++; $display("FAIL rst_mid_nodone got=%b want=0", done);
      end
    end
    set_tile(1, 16'h5800);
    push(tile[0], 1'b1);
    total++;
    if (primed !== 1'b1) begin
      bad++; $display("FAIL rst_one_primed got=%b want=1", primed);
    end
    fire_start();
    for (int k = 1; k <= 1 + FN + 1; k++) begin
      @(negedge clk);
      for (int i = 0; i < LN; i++) begin
        total++;
        if (lane_out[i*W +: W] !== exp_lane(i, k, 1)) begin
          bad++;
          $display("FAIL rst_one_lane%0d k=%0d got=%h want=%h",
                   i, k, lane_out[i*W +: W], exp_lane(i, k, 1));
        end
      end
      total++;
      if (done !== (k == 1 + FN)) begin
        bad++; $display("FAIL rst_one_done k=%0d got=%b", k, done);
      end
    end
  endtask

  task automatic test_ftz();
    logic [LN*W-1:0] raw;
    raw = {16'h0400, 16'h3C00, 16'h0200, 16'h8001};
`ifdef SKEW_FEEDER_FTZ_EN
    tile[0] = {16'h0400, 16'h3C00, 16'h0000, 16'h8000};
`else
    tile[0] = raw;
`endif
    push(raw, 1'b1);
    fire_start();
    for (int k = 1; k <= LN; k++) begin
      @(negedge clk);
      total++;
      if (lane_out[(k-1)*W +: W] !== tile[0][(k-1)*W +: W]) begin
        bad++;
        $display("FAIL ftz_lane%0d got=%h want=%h", k - 1,
                 lane_out[(k-1)*W +: W], tile[0][(k-1)*W +: W]);
      end
    end
    repeat (FN + 2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int pulses;
    pulses = 0;
    for (int t = 0; t < 2; t++) begin
      set_tile(2, (t == 0) ? 16'h6000 : 16'h7000);
      push(tile[0], 1'b0);
      push(tile[1], 1'b1);
      fire_start();
      for (int k = 1; k <= 2 + FN + 1; k++) begin
        @(negedge clk);
        if (done === 1'b1) pulses++;
        for (int i = 0; i < LN; i++) begin
          total++;
          if (lane_out[i*W +: W] !== exp_lane(i, k, 2)) begin
            bad++;
            $display("FAIL b2b_t%0d_lane%0d k=%0d got=%h want=%h",
                     t, i, k, lane_out[i*W +: W], exp_lane(i, k, 2));
          end
        end
        total++;
        if (done !== (k == 2 + FN)) begin
          bad++; $display("FAIL b2b_t%0d_done k=%0d got=%b", t, k, done);
        end
      end
    end
    total++;
    if (pulses != 2) begin
      bad++; $display("FAIL b2b_pulses got=%0d want=2", pulses);
    end
  endtask

  initial begin
    up.in_valid = 1'b0;
    up.in_data  = '0;
    up.in_last  = 1'b0;
    test_reset();
    test_basic_skew();
    test_truncation();
    test_start_gating();
    test_reset_mid();
    test_ftz();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
